// File: rtl/mac_pkg.sv
// Shared types for the MAC dot-product arbiter: widths, FSM states, requester id.
// No logic; no latency or backpressure of its own.
package mac_pkg;
    localparam int DW_DEF = 8;
    localparam int AW_DEF = 17;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, RESULT} state_t;

    typedef logic req_id_t;
endpackage

// File: rtl/mac_rr_arb2.sv
// Two-way round-robin job arbiter; grant is combinational from req and the pointer.
// The pointer moves only on advance, to prefer the requester not granted last.
module mac_rr_arb2
    import mac_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt,
    output req_id_t    gnt_id
);
    req_id_t ptr;
    req_id_t last_id;

    always_comb begin
        gnt_id = ptr;
        if (!req[ptr]) gnt_id = ~ptr;
        gnt = 2'b00;
        if (|req) gnt[gnt_id] = 1'b1;
    end

    // last_id remembers who won, since req is gone by the time advance arrives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= 1'b0;
            last_id <= 1'b0;
        end else begin
            if (|req)   last_id <= gnt_id;
            if (advance) ptr    <= ~last_id;
        end
    end
endmodule

// File: rtl/mac_dot_arbiter.sv
// Shares one pipelined signed MAC between two dot-product requesters, one whole job at a time.
// Result appears 1 + elements + MAC_LAT cycles after grant; res_data/res_id hold until res_ready.
module mac_dot_arbiter
    import mac_pkg::*;
#(
    parameter int DW      = mac_pkg::DW_DEF,
    parameter int AW      = mac_pkg::AW_DEF,
    parameter int MAC_LAT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [DW-1:0] req0_a,
    input  logic [DW-1:0] req0_b,
    input  logic          req0_last,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [DW-1:0] req1_a,
    input  logic [DW-1:0] req1_b,
    input  logic          req1_last,
    output logic [DW-1:0] mac_dataa,
    output logic [DW-1:0] mac_datab,
    output logic          mac_clken,
    output logic          mac_sload,
    input  logic [AW-1:0] mac_result,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [AW-1:0] res_data,
    output logic          res_id
);
    localparam int CW = $clog2(MAC_LAT + 1);

    state_t        state, state_nxt;
    req_id_t       owner;
    logic          first;
    logic [CW-1:0] drain_cnt;
    logic [1:0]    arb_req, arb_gnt;
    req_id_t       gnt_id;
    logic          own_valid, own_last;
    logic [DW-1:0] own_a, own_b;

    assign arb_req   = (state == IDLE) ? {req1_valid, req0_valid} : 2'b00;
    assign own_valid = owner ? req1_valid : req0_valid;
    assign own_last  = owner ? req1_last  : req0_last;
    assign own_a     = owner ? req1_a     : req0_a;
    assign own_b     = owner ? req1_b     : req0_b;

    mac_rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (arb_req),
        .advance ((state == RESULT) && res_ready),
        .gnt     (arb_gnt),
        .gnt_id  (gnt_id)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        mac_dataa  = '0;
        mac_datab  = '0;
        mac_clken  = 1'b0;
        mac_sload  = 1'b0;
        res_valid  = 1'b0;
        case (state)
            IDLE: if (|arb_gnt) state_nxt = STREAM;
            STREAM: begin
                req0_ready = ~owner;
                req1_ready = owner;
                mac_dataa  = own_a;
                mac_datab  = own_b;
                // a gap cycle freezes the MAC pipeline rather than feeding it
                mac_clken  = own_valid;
                mac_sload  = first && own_valid;
                if (own_valid && own_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                mac_clken = 1'b1;
                if (drain_cnt == CW'(1)) state_nxt = RESULT;
            end
            RESULT: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner     <= 1'b0;
            first     <= 1'b0;
            drain_cnt <= '0;
            res_data  <= '0;
            res_id    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|arb_gnt) begin
                    owner <= gnt_id;
                    first <= 1'b1;
                end
                STREAM: if (own_valid) begin
                    first <= 1'b0;
                    if (own_last) drain_cnt <= CW'(MAC_LAT);
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt - CW'(1);
                    if (drain_cnt == CW'(1)) begin
                        res_data <= mac_result;
                        res_id   <= owner;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_dot_arbiter.sv
// Bench for mac_dot_arbiter with a behavioural two-stage MAC and a dot-product reference.
// Directed scenarios followed by randomized jobs with random gaps and result stalls.
module tb_mac_dot_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_last;
    logic [7:0]  req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_last;
    logic [7:0]  req1_a, req1_b;
    logic [7:0]  mac_dataa, mac_datab;
    logic        mac_clken, mac_sload;
    logic [16:0] mac_result;
    logic        res_valid, res_ready, res_id;
    logic [16:0] res_data;

    mac_dot_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_last(req0_last),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_last(req1_last),
        .mac_dataa(mac_dataa), .mac_datab(mac_datab), .mac_clken(mac_clken), .mac_sload(mac_sload),
        .mac_result(mac_result), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_id(res_id)
    );

    always #5 clk = ~clk;

    // MAC: product register then accumulator, both gated by clken
    logic signed [16:0] mac_p, mac_acc;
    logic               mac_sl;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mac_p <= '0; mac_sl <= 1'b0; mac_acc <= '0;
        end else if (mac_clken) begin
            mac_p   <= $signed(mac_dataa) * $signed(mac_datab);
            mac_sl  <= mac_sload;
            mac_acc <= mac_sl ? mac_p : mac_acc + mac_p;
        end
    end
    assign mac_result = mac_acc;

    int n_pass = 0, n_total = 0;
    int stall_pct = 0;
    bit manual_rr = 1'b0, manual_val = 1'b0, abort = 1'b0;
    bit busy [2];
    logic signed [7:0] ja [2][16];
    logic signed [7:0] jb [2][16];
    int jn [2], jgap [2];
    int q_data[$], q_id[$], q_clk[$], q_sl[$];
    int clk_cnt = 0, sl_cnt = 0;

    always @(negedge clk) begin
        res_ready = manual_rr ? manual_val : ($urandom_range(0, 99) >= stall_pct);
        if (!rst_n) begin
            clk_cnt = 0; sl_cnt = 0;
        end else begin
            if (mac_clken) clk_cnt++;
            if (mac_sload) sl_cnt++;
            if (res_valid && res_ready) begin
                q_data.push_back(int'($signed(res_data)));
                q_id.push_back(int'(res_id));
                q_clk.push_back(clk_cnt);
                q_sl.push_back(sl_cnt);
                clk_cnt = 0; sl_cnt = 0;
            end
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int wrap17(input int s);
        logic signed [16:0] t;
        t = s[16:0];
        return int'(t);
    endfunction

    function automatic int dot(input int id);
        int s = 0;
        for (int i = 0; i < jn[id]; i++) s += int'(ja[id][i]) * int'(jb[id][i]);
        return wrap17(s);
    endfunction

    task automatic set_elem(input int id, input int i, input int a, input int b);
        ja[id][i] = a[7:0];
        jb[id][i] = b[7:0];
    endtask

    task automatic drive(input int id, input logic v, input logic [7:0] a, input logic [7:0] b, input logic l);
        if (id == 0) begin
            req0_valid = v; req0_a = a; req0_b = b; req0_last = l;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b; req1_last = l;
        end
    endtask

    // Called just after a falling edge; returns just after a falling edge.
    task automatic send(input int id);
        busy[id] = 1'b1;
        for (int i = 0; i < jn[id]; i++) begin
            if (i > 0)
                for (int g = 0; g < jgap[id] && !abort; g++) begin
                    drive(id, 1'b0, 8'h00, 8'h00, 1'b0);
                    @(negedge clk);
                end
            if (abort) break;
            drive(id, 1'b1, ja[id][i], jb[id][i], i == jn[id] - 1);
            for (int w = 0; !abort; w++) begin
                if ((id == 0) ? req0_ready : req1_ready) begin
                    @(posedge clk);
                    break;
                end
                if (w > 500) begin
                    n_total++;
                    $error("FAIL accept_timeout: requester %0d element %0d not accepted", id, i);
                    break;
                end
                @(negedge clk);
            end
            @(negedge clk);
        end
        drive(id, 1'b0, 8'h00, 8'h00, 1'b0);
        busy[id] = 1'b0;
    endtask

    task automatic expect_job(input string tag, input int exp_d, input int exp_id, input int n);
        int w;
        for (w = 0; w < 300 && q_data.size() == 0; w++) @(negedge clk);
        if (q_data.size() == 0) begin
            n_total++;
            $error("FAIL %s_timeout: no result after %0d cycles", tag, w);
        end else begin
            check({tag, "_data"},  q_data.pop_front(), exp_d);
            check({tag, "_id"},    q_id.pop_front(),   exp_id);
            check({tag, "_clken"}, q_clk.pop_front(),  n + 2);
            check({tag, "_sload"}, q_sl.pop_front(),   1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, d0, i0, exp_d, id, n;
        drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready0", int'(req0_ready), 0);
        check("rst_ready1", int'(req1_ready), 0);
        check("rst_clken",  int'(mac_clken), 0);
        check("rst_sload",  int'(mac_sload), 0);
        check("rst_dataa",  int'(mac_dataa), 0);
        check("rst_resv",   int'(res_valid), 0);
        check("rst_resd",   int'(res_data), 0);
        check("rst_resid",  int'(res_id), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // both requesters at once after reset: req0 preferred, latency 1+1+MAC_LAT
        jn[0] = 1; jgap[0] = 0; set_elem(0, 0, 1, 1);
        jn[1] = 2; jgap[1] = 0; set_elem(1, 0, 2, 4); set_elem(1, 1, 3, 5);
        lat = 0;
        fork
            send(0);
            send(1);
            begin
                while (!res_valid && lat < 100) begin @(negedge clk); lat++; end
            end
        join
        check("latency", lat, 4);
        expect_job("both_r0", 1, 0, 1);
        expect_job("both_r1", 23, 1, 2);

        // three-element vector, continuous valid
        jn[0] = 3; jgap[0] = 0;
        set_elem(0, 0, -1, -128); set_elem(0, 1, 55, 127); set_elem(0, 2, -121, -128);
        send(0);
        expect_job("vec3", 22601, 0, 3);

        // req0 just served, so req1 wins a simultaneous request
        jn[0] = 1; jgap[0] = 0; set_elem(0, 0, 3, 3);
        jn[1] = 1; jgap[1] = 0; set_elem(1, 0, -2, 5);
        fork send(0); send(1); join
        expect_job("flip_r1", -10, 1, 1);
        expect_job("flip_r0", 9, 0, 1);

        // same vector with two idle cycles between beats
        jn[0] = 3; jgap[0] = 2;
        set_elem(0, 0, -1, -128); set_elem(0, 1, 55, 127); set_elem(0, 2, -121, -128);
        send(0);
        expect_job("gaps", 22601, 0, 3);

        // accumulator wraps modulo 2^17
        jn[1] = 5; jgap[1] = 0;
        for (int i = 0; i < 5; i++) set_elem(1, i, -128, -128);
        send(1);
        expect_job("wrap", -49152, 1, 5);

        // result held while res_ready stays low
        #2 manual_val = 1'b0; manual_rr = 1'b1;
        @(negedge clk);
        jn[0] = 2; jgap[0] = 0; set_elem(0, 0, 10, -10); set_elem(0, 1, -3, 4);
        send(0);
        for (int w = 0; w < 50 && !res_valid; w++) @(negedge clk);
        d0 = int'($signed(res_data)); i0 = int'(res_id);
        check("hold_data0", d0, -112);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("hold_valid%0d", k), int'(res_valid), 1);
            check($sformatf("hold_data%0d", k), int'($signed(res_data)), d0);
            check($sformatf("hold_id%0d", k), int'(res_id), i0);
            check($sformatf("hold_rdy%0d", k), int'({req0_ready, req1_ready}), 0);
            check($sformatf("hold_clken%0d", k), int'(mac_clken), 0);
            @(negedge clk);
        end
        #2 manual_val = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("hold_release", int'(res_valid), 0);
        expect_job("hold", -112, 0, 2);
        #2 manual_rr = 1'b0;
        @(negedge clk);

        // randomized jobs with random gaps and result stalls
        stall_pct = 30;
        for (int j = 0; j < 14; j++) begin
            id = $urandom_range(0, 1);
            n = $urandom_range(1, 6);
            jn[id] = n; jgap[id] = $urandom_range(0, 2);
            for (int i = 0; i < n; i++)
                set_elem(id, i, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            exp_d = dot(id);
            send(id);
            expect_job($sformatf("rnd%0d", j), exp_d, id, n);
        end
        stall_pct = 0;
        @(negedge clk);

        // reset in the middle of a streaming job
        jn[0] = 3; jgap[0] = 2;
        set_elem(0, 0, 9, 9); set_elem(0, 1, 8, 8); set_elem(0, 2, 7, 7);
        fork send(0); join_none
        repeat (4) @(negedge clk);
        check("mid_ready_before", int'(req0_ready), 1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_ready0", int'(req0_ready), 0);
        check("mid_clken", int'(mac_clken), 0);
        check("mid_sload", int'(mac_sload), 0);
        check("mid_resv", int'(res_valid), 0);
        check("mid_resd", int'(res_data), 0);
        abort = 1'b1;
        for (int w = 0; w < 50 && busy[0]; w++) @(negedge clk);
        check("mid_abort_done", int'(busy[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        abort = 1'b0;
        @(negedge clk);
        jn[1] = 1; jgap[1] = 0; set_elem(1, 0, 7, -3);
        send(1);
        expect_job("post_rst", -21, 1, 1);
        check("post_rst_queue", q_data.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
